// File: rtl/pipeline_mon_pkg.sv
// Shared types for the pipeline run monitor.
//   run_state_e : run controller states
//   log_entry_t : one captured data-memory write {addr, data}
// PKG_ADDR_W / PKG_DATA_W are the default bus widths; the top level uses
// them as its own parameter defaults, so the log entry layout matches the
// core buses.
package pipeline_mon_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_RESET,
        RUN,
        PASS,
        FAIL
    } run_state_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
    } log_entry_t;

endpackage

// File: rtl/mon_write_log.sv
// Write log for the run monitor: keeps the first LOG_DEPTH writes of a run
// in append order (no wrap-around) and flags any write that did not fit.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   clear          : empties the log (count and overflow) at the next edge
//   wr_en          : append wr_entry this cycle
//   wr_entry       : {addr, data} to append
//   rd_idx         : read index
//   rd_entry       : entry at rd_idx (combinational read)
//   count          : number of valid entries (0..LOG_DEPTH)
//   overflow       : at least one write was dropped because the log was full
module mon_write_log
    import pipeline_mon_pkg::*;
#(
    parameter int LOG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  log_entry_t                   wr_entry,
    input  logic [$clog2(LOG_DEPTH)-1:0] rd_idx,
    output log_entry_t                   rd_entry,
    output logic [$clog2(LOG_DEPTH):0]   count,
    output logic                         overflow
);

    localparam int IDX_W = $clog2(LOG_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LOG_DEPTH);

    log_entry_t       entries_q [LOG_DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full;

    assign full = (count_q == DEPTH_CNT);

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (wr_en) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is not reset: contents beyond count are meaningless.
    always_ff @(posedge clk) begin
        if (wr_en && !clear && !full) begin
            entries_q[count_q[IDX_W-1:0]] <= wr_entry;
        end
    end

    assign rd_entry = entries_q[rd_idx];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run controller and memory-write monitor for the pipelined core.
// Holds the core in reset until start, releases it after RESET_CYCLES,
// counts RUN cycles, logs data-memory writes and ends the run with PASS
// when DONE_VALUE is written to DONE_ADDR, FAIL on any other value written
// there, or FAIL+timeout after TIMEOUT RUN cycles.
// Ports:
//   clk, reset (async, active-low), start (one-cycle run request)
//   mem_write, data_addr, write_data : core data-memory write bus
//   core_reset : active-high reset to the core
//   busy / done / pass / timeout     : run status (registered)
//   cycle_count : RUN cycles elapsed (saturating)
//   log_count, log_overflow          : write log status
//   log_rd_idx -> log_rd_addr/log_rd_data : combinational log read port
module pipeline_run_monitor
    import pipeline_mon_pkg::*;
#(
    parameter int              DATA_W       = PKG_DATA_W,
    parameter int              ADDR_W       = PKG_ADDR_W,
    parameter int              RESET_CYCLES = 3,
    parameter int              TIMEOUT      = 4096,
    parameter longint unsigned DONE_ADDR    = 'h64,
    parameter longint unsigned DONE_VALUE   = 7,
    parameter int              LOG_DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mem_write,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic [DATA_W-1:0]            write_data,
    output logic                         core_reset,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [31:0]                  cycle_count,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
    output logic [ADDR_W-1:0]            log_rd_addr,
    output logic [DATA_W-1:0]            log_rd_data
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [31:0]       CYCLE_LAST  = 32'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] SIG_ADDR    = ADDR_W'(DONE_ADDR);
    localparam logic [DATA_W-1:0] SIG_VALUE   = DATA_W'(DONE_VALUE);

    run_state_e        state_q, state_d;
    logic [1:0]        rst_sync_q, rst_sync_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              log_clear;
    logic              log_wr_en;
    logic              sig_write;
    log_entry_t        log_wr_entry;
    log_entry_t        log_rd_entry;

    // Reset release is seen by the FSM only after two clean edges, so a
    // start arriving right at deassertion cannot leave IDLE metastably.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    assign log_wr_en = (state_q == RUN) && mem_write;
    assign sig_write = log_wr_en && (data_addr == SIG_ADDR);

    always_comb begin
        log_wr_entry      = '0;
        log_wr_entry.addr = data_addr;
        log_wr_entry.data = write_data;
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        log_clear   = 1'b0;

        case (state_q)
            IDLE, PASS, FAIL: begin
                if (start && rst_sync_q[1]) begin
                    state_d     = HOLD_RESET;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    log_clear   = 1'b1;
                end
            end
            HOLD_RESET: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // A signature write wins over the timeout in the same cycle;
                // cycle_count keeps the index of the terminating cycle.
                if (sig_write) begin
                    pass_d  = (write_data == SIG_VALUE);
                    state_d = (write_data == SIG_VALUE) ? PASS : FAIL;
                end else if (cycle_cnt_q == CYCLE_LAST) begin
                    state_d   = FAIL;
                    timeout_d = 1'b1;
                end else if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        core_reset_d = (state_d == IDLE) || (state_d == HOLD_RESET);
        busy_d       = (state_d == HOLD_RESET) || (state_d == RUN);
        done_d       = (state_d == PASS) || (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rst_sync_q   <= 2'b00;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_sync_q   <= rst_sync_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    mon_write_log #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .reset    (reset),
        .clear    (log_clear),
        .wr_en    (log_wr_en),
        .wr_entry (log_wr_entry),
        .rd_idx   (log_rd_idx),
        .rd_entry (log_rd_entry),
        .count    (log_count),
        .overflow (log_overflow)
    );

    assign core_reset  = core_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_cnt_q;
    assign log_rd_addr = log_rd_entry.addr;
    assign log_rd_data = log_rd_entry.data;

endmodule

// File: tb/tb_pipeline_run_monitor.sv
module tb_pipeline_run_monitor;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_DEPTH   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        core_reset, busy, done, pass, timeout, log_overflow;
    logic [31:0] cycle_count;
    logic [3:0]  log_count;
    logic [2:0]  log_rd_idx = '0;
    logic [31:0] log_rd_addr, log_rd_data;

    pipeline_run_monitor #(
        .DATA_W(32), .ADDR_W(32), .RESET_CYCLES(3), .TIMEOUT(TB_TIMEOUT),
        .DONE_ADDR('h64), .DONE_VALUE(7), .LOG_DEPTH(TB_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
        .data_addr(data_addr), .write_data(write_data), .core_reset(core_reset),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cycle_count(cycle_count), .log_count(log_count), .log_overflow(log_overflow),
        .log_rd_idx(log_rd_idx), .log_rd_addr(log_rd_addr), .log_rd_data(log_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pass;
        logic             tmo;
        logic [31:0]      cyc;
        logic [3:0]       lcount;
        logic             ovf;
        logic [7:0][31:0] la;
        logic [7:0][31:0] ld;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          checked_cnt = 0;
    int          run_id = 0;
    bit          mon_prev = 1'b0;

    // Run plan: what the core writes in each RUN cycle index.
    bit          plan_we   [TB_TIMEOUT];
    logic [31:0] plan_addr [TB_TIMEOUT];
    logic [31:0] plan_data [TB_TIMEOUT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the plan in run order; the first LOG_DEPTH writes are
    // kept, a DONE_ADDR write ends the run, otherwise the last allowed cycle
    // ends it with a timeout.
    function automatic exp_t model(output int kend);
        exp_t e;
        e = '0;
        kend = TB_TIMEOUT - 1;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            if (plan_we[k]) begin
                if (e.lcount < 4'(TB_DEPTH)) begin
                    e.la[e.lcount[2:0]] = plan_addr[k];
                    e.ld[e.lcount[2:0]] = plan_data[k];
                    e.lcount = e.lcount + 4'd1;
                end else begin
                    e.ovf = 1'b1;
                end
                if (plan_addr[k] == 32'h64) begin
                    e.pass = (plan_data[k] == 32'd7);
                    e.cyc  = 32'(k);
                    kend   = k;
                    return e;
                end
            end
            if (k == TB_TIMEOUT - 1) begin
                e.tmo = 1'b1;
                e.cyc = 32'(k);
                kend  = k;
                return e;
            end
        end
        return e;
    endfunction

    task automatic clear_plan();
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            plan_we[k]   = 1'b0;
            plan_addr[k] = '0;
            plan_data[k] = '0;
        end
    endtask

    task automatic set_w(input int k, input logic [31:0] a, input logic [31:0] d);
        plan_we[k]   = 1'b1;
        plan_addr[k] = a;
        plan_data[k] = d;
    endtask

    task automatic random_plan();
        logic [31:0] a;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            plan_we[k] = ($urandom % 3) != 0;
            if (($urandom % 12) == 0) begin
                a = 32'h64;
                plan_data[k] = ($urandom % 2) ? 32'd7 : 32'($urandom % 16);
            end else begin
                a = {24'd0, 6'($urandom % 64), 2'b00};
                if (a == 32'h64) a = 32'h68;
                plan_data[k] = $urandom;
            end
            plan_addr[k] = a;
        end
    endtask

    // Caller is 1 time unit after a rising edge with the DUT idle or finished.
    task automatic do_run(input bit rand_start);
        exp_t e;
        int   kend;
        int   c0;
        e = model(kend);
        exp_q.push_back(e);
        c0 = checked_cnt;
        start = 1'b1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        // Reset hold: writes here (even the signature) must be ignored.
        for (int h = 0; h < 3; h++) begin
            check("hold_core_reset", core_reset, 1);
            check("hold_busy", busy, 1);
            mem_write  = 1'b1;
            data_addr  = 32'h64;
            write_data = 32'd7;
            start      = rand_start ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
        end
        check("run_core_reset", core_reset, 0);
        for (int k = 0; k <= kend; k++) begin
            check("run_cycle_count", cycle_count, 64'(k));
            check("run_busy", busy, 1);
            mem_write  = plan_we[k];
            data_addr  = plan_addr[k];
            write_data = plan_data[k];
            start      = rand_start ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        // Terminal state: writes must neither be logged nor re-judged.
        for (int j = 0; j < 3; j++) begin
            mem_write  = 1'b1;
            data_addr  = (j == 0) ? 32'h64 : 32'h20;
            write_data = (j == 0) ? ~e.ld[0] ^ 32'd7 : 32'd7;
            @(posedge clk); #1;
        end
        mem_write = 1'b0;
        for (int w = 0; w < 40 && checked_cnt == c0; w++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (checked_cnt == c0) begin
            n_fail++;
            $display("FAIL run_complete: run %0d got no done within bound, expected done", run_id);
            exp_q.delete();
        end
        run_id++;
    endtask

    // Scoreboard monitor: on each done rising edge, wait a few cycles so that
    // writes after completion would show up, then compare with the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !mon_prev) begin
                repeat (4) @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: got done, expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    check("done", done, 1);
                    check("busy_end", busy, 0);
                    check("core_reset_end", core_reset, 0);
                    check("pass", pass, 64'(e.pass));
                    check("timeout", timeout, 64'(e.tmo));
                    check("cycle_count", cycle_count, 64'(e.cyc));
                    check("log_count", log_count, 64'(e.lcount));
                    check("log_overflow", log_overflow, 64'(e.ovf));
                    for (int i = 0; i < int'(e.lcount); i++) begin
                        log_rd_idx = 3'(i);
                        #1;
                        check("log_addr", log_rd_addr, 64'(e.la[i]));
                        check("log_data", log_rd_data, 64'(e.ld[i]));
                    end
                    $display("run done: pass=%0d timeout=%0d cycles=%0d log_count=%0d overflow=%0d",
                             pass, timeout, cycle_count, log_count, log_overflow);
                end
                checked_cnt++;
            end
            mon_prev = done;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_log_count"}, log_count, 0);
        check({tag, "_log_overflow"}, log_overflow, 0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(posedge clk);
            #1;
            check_idle("idle");
        end

        // Basic pass: two writes then the signature.
        clear_plan();
        set_w(0, 32'h10, 32'd1);
        set_w(1, 32'h14, 32'd2);
        set_w(2, 32'h64, 32'd7);
        do_run(1'b0);

        // Wrong signature value.
        clear_plan();
        set_w(1, 32'h30, 32'hdead);
        set_w(3, 32'h64, 32'd5);
        do_run(1'b0);

        // No writes: timeout at the last cycle.
        clear_plan();
        do_run(1'b0);

        // Signature exactly in the timeout cycle wins.
        clear_plan();
        set_w(15, 32'h64, 32'd7);
        do_run(1'b0);

        // Log overflow: ten writes, then the signature.
        clear_plan();
        for (int k = 0; k < 10; k++) set_w(k, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k));
        set_w(10, 32'h64, 32'd7);
        do_run(1'b1);

        // Reset dropped in the middle of a run.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        mem_write = 1'b1; data_addr = 32'h40; write_data = 32'h55;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        mem_write = 1'b0;
        check_idle("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_idle("after_reset");

        clear_plan();
        set_w(0, 32'h10, 32'd1);
        set_w(1, 32'h14, 32'd2);
        set_w(2, 32'h64, 32'd7);
        do_run(1'b0);

        for (int r = 0; r < 25; r++) begin
            random_plan();
            do_run(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_run_monitor.md
# pipeline_run_monitor

Synthesizable run controller and memory-write monitor for the pipelined processor.
- Sequences the core's reset and counts execution cycles.
- Logs every data-memory write the core performs.
- Declares pass or fail when the core writes a completion signature to a designated address, or when a timeout expires.
- Sits beside the processor, replacing hand-written reset pulses and waveform inspection in both simulation and FPGA bring-up.

## Interface
Parameters:
- DATA_W, 32, width of write data and result bus
- ADDR_W, 32, width of data address
- RESET_CYCLES, 3, cycles core_reset is held after start (≥1)
- TIMEOUT, 4096, maximum RUN cycles before fail (≥2)
- DONE_ADDR, 'h64, completion address
- DONE_VALUE, 7, expected completion value
- LOG_DEPTH, 8, write-log entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  one-cycle run request
- mem_write  in  1  core MemWrite
- data_addr  in  ADDR_W  core data address
- write_data  in  DATA_W  core WriteData
- core_reset  out  1  active-high reset to the core
- busy  out  1  in HOLD_RESET or RUN
- done  out  1  run finished (PASS or FAIL)
- pass  out  1  correct signature written
- timeout  out  1  fail caused by timeout
- cycle_count  out  32  RUN cycles elapsed
- log_count  out  $clog2(LOG_DEPTH)+1  valid log entries
- log_overflow  out  1  writes were dropped
- log_rd_idx  in  $clog2(LOG_DEPTH)  log read index
- log_rd_addr  out  ADDR_W  logged address at idx (combinational)
- log_rd_data  out  DATA_W  logged data at idx (combinational)

## Operation
- FSM states: IDLE, HOLD_RESET, RUN, PASS, FAIL.
- IDLE/PASS/FAIL → HOLD_RESET on start. The transition clears cycle_count, log_count, log_overflow, pass and timeout.
- HOLD_RESET lasts exactly RESET_CYCLES cycles with core_reset=1, then goes to RUN. start is ignored in this state.
- RUN rules:
  - cycle_count increments every cycle.
  - mem_write=1 appends {data_addr, write_data} at index log_count while log_count<LOG_DEPTH. Otherwise it sets log_overflow and the entry is dropped; the first LOG_DEPTH writes are kept, with no wrap-around.
  - mem_write=1 with data_addr==DONE_ADDR and write_data==DONE_VALUE → PASS.
  - mem_write=1 with data_addr==DONE_ADDR and any other value → FAIL.
  - Otherwise, cycle_count==TIMEOUT-1 → FAIL with timeout=1.
- The signature write is itself logged, or sets log_overflow if the log is full.
- In RUN, start is ignored.
- Writes outside RUN are neither logged nor checked.
- Terminal states hold all outputs until the next start. core_reset stays 0 so the core keeps running and the log is frozen.
- cycle_count saturates at all-ones.

## Timing
- Reset values: state IDLE; core_reset=1; busy=0; done=0; pass=0; timeout=0; cycle_count=0; log_count=0; log_overflow=0.
- core_reset=1 in IDLE, so the core is held until the first start. It is 0 in RUN, PASS and FAIL.
- Reset deassertion is synchronized internally with a 2-flop synchronizer before leaving IDLE.
- start at edge N → HOLD_RESET from N+1. core_reset is high for cycles N+1..N+RESET_CYCLES. First RUN cycle is N+RESET_CYCLES+1, with cycle_count=0 in that cycle.
- The signature write sampled at an edge sets done/pass at that same edge, visible the following cycle. cycle_count then holds that write's cycle index.
- A signature write in the timeout cycle takes priority: PASS, timeout=0.
- Reset asserted mid-run forces IDLE and all reset values immediately (asynchronous). The log contents become don't-care.
- Outputs are registered, except log_rd_addr/log_rd_data.

## Structure
- Package pipeline_mon_pkg holds:
  - run_state_e enum (IDLE, HOLD_RESET, RUN, PASS, FAIL)
  - log_entry_t struct {addr, data}, parametrised via package parameters DATA_W/ADDR_W defaults
- One sub-module, mon_write_log: LOG_DEPTH×log_entry_t register array with append pointer, count, overflow flag and asynchronous read port.
- Top level contains the FSM, reset-hold counter, cycle counter and signature comparator.

## Test plan
- Reset low 3 cycles then high, no start → core_reset=1, busy=0, done=0, cycle_count=0 indefinitely.
- start, RESET_CYCLES=3 → core_reset high exactly 3 cycles. Then writes (0x10,1), (0x14,2), (0x64,7) → pass=1, done=1, log_count=3, log_rd_idx=2 reads {0x64,7}.
- Write (0x64,5) → done=1, pass=0, timeout=0.
- No writes, TIMEOUT=16 → done=1, timeout=1 with cycle_count=15. A signature write exactly in that cycle instead → pass=1, timeout=0.
- LOG_DEPTH=8 with 10 non-signature writes, then signature → log_count=8, log_overflow=1, idx 7 holds the 8th write, pass=1.
- Reset dropped mid-RUN → all outputs return to reset values immediately. A new start runs cleanly with the log cleared.
